// File: rtl/clkdiv_prog.sv
// clkdiv_prog: runtime-programmable integer clock divider.
//
// Divides clk_in by N = active_div (2..2^WIDTH-1). Divisor updates and
// enable changes are applied only at period boundaries (cnt == N-1), so
// clk_out never produces a truncated phase. A one-cycle tick accompanies
// every rising edge of clk_out for logic remaining in the clk_in domain.
//
// Optional build macro: CLKDIV_DUTY50_EN
//   defined   - odd N gives exactly 50% duty using a falling-edge retimed
//               copy of the phase register OR'd onto clk_out.
//   undefined - odd N is high ceil(N/2), low floor(N/2); no negedge logic.
//
// Ports:
//   clk_in      source clock, all state updates on rising edge
//   reset       asynchronous active-high reset
//   en          run request, sampled only at period boundaries
//   div_load    strobe capturing div_value as the next divisor
//   div_value   requested divisor (0 and 1 are clamped to 2)
//   div_pending a loaded divisor awaits the next boundary
//   active_div  divisor currently in use
//   clk_out     divided clock
//   tick        one-cycle pulse at each clk_out rising edge
//   running     divider is producing periods
module clkdiv_prog #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned RESET_DIV = 4
) (
   input  logic             clk_in,
   input  logic             reset,
   input  logic             en,
   input  logic             div_load,
   input  logic [WIDTH-1:0] div_value,
   output logic             div_pending,
   output logic [WIDTH-1:0] active_div,
   output logic             clk_out,
   output logic             tick,
   output logic             running
);

   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
   localparam logic [WIDTH-1:0] TWO     = WIDTH'(2);
   localparam logic [WIDTH-1:0] RST_DIV = WIDTH'(RESET_DIV);
   localparam logic [WIDTH-1:0] RST_CNT = WIDTH'(RESET_DIV - 1);
   localparam logic [WIDTH:0]   ONE_W   = (WIDTH+1)'(1);

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] active_q, active_d;
   logic [WIDTH-1:0] pend_q, pend_d;
   logic             pflag_q, pflag_d;
   logic             clk_q, clk_d;
   logic             tick_q, tick_d;
   logic             run_q, run_d;

   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] cnt_nx;
   logic [WIDTH:0]   half;
   logic             boundary;

   always_comb begin
      load_val = (div_value < TWO) ? TWO : div_value;
      boundary = (cnt_q == active_q - ONE);
      cnt_nx   = cnt_q + ONE;
`ifdef CLKDIV_DUTY50_EN
      // Odd N: phase register is high floor(N/2) cycles; the negedge copy
      // adds the missing half cycle. Even N: N>>1 equals N/2 unchanged.
      half     = {1'b0, active_q} >> 1;
`else
      half     = ({1'b0, active_q} + ONE_W) >> 1;
`endif

      cnt_d    = cnt_q;
      active_d = active_q;
      pend_d   = pend_q;
      pflag_d  = pflag_q;
      clk_d    = clk_q;
      tick_d   = 1'b0;
      run_d    = run_q;

      if (boundary) begin
         // A load on the boundary itself bypasses the pending register.
         if (div_load) begin
            active_d = load_val;
            pflag_d  = 1'b0;
         end else if (pflag_q) begin
            active_d = pend_q;
            pflag_d  = 1'b0;
         end
         if (en) begin
            cnt_d  = '0;
            clk_d  = 1'b1;
            tick_d = 1'b1;
            run_d  = 1'b1;
         end else begin
            // Park on the (possibly new) N-1 so the stopped state is
            // itself a boundary and the next en=1 edge starts a period.
            cnt_d = active_d - ONE;
            clk_d = 1'b0;
            run_d = 1'b0;
         end
      end else begin
         cnt_d = cnt_nx;
         clk_d = ({1'b0, cnt_nx} < half);
         if (div_load) begin
            pend_d  = load_val;
            pflag_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         cnt_q    <= RST_CNT;
         active_q <= RST_DIV;
         pend_q   <= '0;
         pflag_q  <= 1'b0;
         clk_q    <= 1'b0;
         tick_q   <= 1'b0;
         run_q    <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         active_q <= active_d;
         pend_q   <= pend_d;
         pflag_q  <= pflag_d;
         clk_q    <= clk_d;
         tick_q   <= tick_d;
         run_q    <= run_d;
      end
   end

`ifdef CLKDIV_DUTY50_EN
   logic neg_q;

   // Retimed half a cycle late; only extends the high phase for odd N.
   always_ff @(negedge clk_in or posedge reset) begin
      if (reset) neg_q <= 1'b0;
      else       neg_q <= clk_q & active_q[0];
   end

   assign clk_out = clk_q | neg_q;
`else
   assign clk_out = clk_q;
`endif

   assign div_pending = pflag_q;
   assign active_div  = active_q;
   assign tick        = tick_q;
   assign running     = run_q;

endmodule

// File: tb/tb_clkdiv_prog.sv
// Directed testbench for clkdiv_prog (default parameters WIDTH=8, RESET_DIV=4).
module tb_clkdiv_prog;

   logic       clk_in = 1'b0;
   logic       reset;
   logic       en;
   logic       div_load;
   logic [7:0] div_value;
   logic       div_pending;
   logic [7:0] active_div;
   logic       clk_out;
   logic       tick;
   logic       running;

   int unsigned n_chk  = 0;
   int unsigned n_fail = 0;

   clkdiv_prog #(.WIDTH(8), .RESET_DIV(4)) dut (
      .clk_in      (clk_in),
      .reset       (reset),
      .en          (en),
      .div_load    (div_load),
      .div_value   (div_value),
      .div_pending (div_pending),
      .active_div  (active_div),
      .clk_out     (clk_out),
      .tick        (tick),
      .running     (running)
   );

   always #5 clk_in = ~clk_in;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // One rising edge, then check the state expected at position i of an N period.
   task automatic exp_cyc(input int n, input int i);
      @(posedge clk_in); #1;
      check($sformatf("clk_n%0d_i%0d", n, i), 32'(clk_out), 32'(i < (n + 1) / 2));
      check($sformatf("tick_n%0d_i%0d", n, i), 32'(tick), 32'(i == 0));
      check($sformatf("run_n%0d_i%0d", n, i), 32'(running), 32'd1);
      check($sformatf("div_n%0d_i%0d", n, i), 32'(active_div), 32'(n));
   endtask

   task automatic exp_period(input int n);
      for (int i = 0; i < n; i++) exp_cyc(n, i);
   endtask

   task automatic exp_stop(input int n);
      @(posedge clk_in); #1;
      check("stop_clk", 32'(clk_out), 32'd0);
      check("stop_tick", 32'(tick), 32'd0);
      check("stop_run", 32'(running), 32'd0);
      check("stop_div", 32'(active_div), 32'(n));
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int hi;
      reset     = 1'b1;
      en        = 1'b0;
      div_load  = 1'b0;
      div_value = '0;

      #2;
      check("rst_clk", 32'(clk_out), 32'd0);
      check("rst_tick", 32'(tick), 32'd0);
      check("rst_run", 32'(running), 32'd0);
      check("rst_div", 32'(active_div), 32'd4);
      check("rst_pend", 32'(div_pending), 32'd0);

      @(posedge clk_in);
      @(negedge clk_in);
      reset = 1'b0;
      en    = 1'b1;

      // Default divide-by-4.
      repeat (3) exp_period(4);

      // Load 5 in cycle 2: current period still 4 long.
      exp_cyc(4, 0);
      exp_cyc(4, 1);
      div_load = 1'b1; div_value = 8'd5;
      exp_cyc(4, 2);
      div_load = 1'b0;
      check("pend_after_load5", 32'(div_pending), 32'd1);
      exp_cyc(4, 3);
      check("pend_before_bnd", 32'(div_pending), 32'd1);
      exp_period(5);
      check("pend_after_bnd5", 32'(div_pending), 32'd0);
      exp_period(5);

      // Last write wins: 7 then 9.
      exp_cyc(5, 0);
      div_load = 1'b1; div_value = 8'd7;
      exp_cyc(5, 1);
      div_value = 8'd9;
      exp_cyc(5, 2);
      div_load = 1'b0;
      check("pend_after_7_9", 32'(div_pending), 32'd1);
      exp_cyc(5, 3);
      exp_cyc(5, 4);
      exp_period(9);
      check("pend_after_bnd9", 32'(div_pending), 32'd0);

      // Load 0 on the boundary edge: clamps to 2, bypasses pending.
      div_load = 1'b1; div_value = 8'd0;
      exp_cyc(2, 0);
      div_load = 1'b0;
      check("pend_bypass0", 32'(div_pending), 32'd0);
      exp_cyc(2, 1);
      // Load 1 mid-period: clamps to 2 via pending.
      exp_cyc(2, 0);
      div_load = 1'b1; div_value = 8'd1;
      exp_cyc(2, 1);
      div_load = 1'b0;
      check("pend_load1", 32'(div_pending), 32'd1);
      exp_period(2);
      check("pend_after_bnd2", 32'(div_pending), 32'd0);
      exp_period(2);

      // N=6, drop en in cycle 1: period completes, then stop.
      div_load = 1'b1; div_value = 8'd6;
      exp_cyc(6, 0);
      div_load = 1'b0;
      en = 1'b0;
      for (int i = 1; i < 6; i++) exp_cyc(6, i);
      repeat (3) exp_stop(6);
      en = 1'b1;
      exp_period(6);

      // N=10, load pending, async reset in cycle 3.
      div_load = 1'b1; div_value = 8'd10;
      exp_cyc(10, 0);
      div_load = 1'b0;
      exp_cyc(10, 1);
      exp_cyc(10, 2);
      div_load = 1'b1; div_value = 8'd12;
      exp_cyc(10, 3);
      div_load = 1'b0;
      check("pend_before_rst", 32'(div_pending), 32'd1);
      #2 reset = 1'b1;
      #1;
      check("async_rst_clk", 32'(clk_out), 32'd0);
      check("async_rst_run", 32'(running), 32'd0);
      check("async_rst_div", 32'(active_div), 32'd4);
      check("async_rst_pend", 32'(div_pending), 32'd0);
      @(negedge clk_in);
      reset = 1'b0;
      repeat (2) exp_period(4);
      check("pend_gone", 32'(div_pending), 32'd0);

      // N=5 high time counted in half cycles.
      div_load = 1'b1; div_value = 8'd5;
      hi = 0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk_in); #1;
         div_load = 1'b0;
         if (i == 0) check("duty_tick", 32'(tick), 32'd1);
         if (clk_out === 1'b1) hi++;
         @(negedge clk_in); #1;
         if (clk_out === 1'b1) hi++;
      end
`ifdef CLKDIV_DUTY50_EN
      check("duty_hi_halves", 32'(hi), 32'd5);
`else
      check("duty_hi_halves", 32'(hi), 32'd6);
`endif
      exp_period(5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/clkdiv_prog.md
Name: clkdiv_prog

Overview:
- Runtime-programmable integer clock divider; successor to the fixed compile-time divide-by-N block.
- Divides clk_in by any N in 2..2^WIDTH-1, odd or even.
- Divisor changes and enable/disable take effect only at period boundaries, so clk_out never glitches.
- Also provides a one-cycle tick strobe at each output period start, for logic that stays in the clk_in domain.

Parameters:
- WIDTH, 8, width of the divisor and internal counter.
- RESET_DIV, 4, divisor active after reset; must be in 2..2^WIDTH-1.

Ports:
- clk_in  input  1  source clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  run request; sampled only at period boundaries.
- div_load  input  1  single-cycle strobe; captures div_value into the pending register.
- div_value  input  WIDTH  requested divisor.
- div_pending  output  1  high while a loaded divisor is waiting for the next boundary.
- active_div  output  WIDTH  divisor currently in use.
- clk_out  output  1  divided clock, registered.
- tick  output  1  one clk_in cycle pulse, coincident with each rising edge of clk_out.
- running  output  1  high while the divider is producing periods.

Behaviour:
- Reset (async, immediate) values:
  - cnt=RESET_DIV-1, active_div=RESET_DIV.
  - pending=0, div_pending=0.
  - clk_out=0, tick=0, running=0.
- Definitions:
  - N = active_div.
  - H = ceil(N/2).
  - Boundary edge = a rising edge where cnt==N-1.
- Running edge (not at a boundary):
  - cnt <= cnt+1; clk_out <= (cnt+1 < H); tick <= 0.
- Boundary edge with en=1:
  - If a divisor is pending or loading, active_div takes the new value first.
  - cnt <= 0; clk_out <= 1; tick <= 1; running <= 1.
  - Result: period = N cycles, high for H cycles, low for floor(N/2) cycles. Even N gives exact 50% duty.
- Boundary edge with en=0:
  - Divider stops: cnt holds at N-1, clk_out <= 0, tick <= 0, running <= 0.
  - A pending divisor is still applied to active_div at that edge.
  - When stopped, the first edge with en=1 starts a new period (clk_out=1, tick=1).
- en deasserted mid-period: the current period completes in full. No truncated high or low phase.
- Divisor load:
  - On a div_load edge, pending <= clamp(div_value) and div_pending <= 1.
  - clamp: values 0 and 1 become 2.
  - div_pending clears on the edge that transfers the value into active_div.
- Load on the boundary edge itself: the new value bypasses pending and is used for the period that starts on that edge. div_pending stays 0.
- Multiple loads before a boundary: last write wins. Only the final value is applied.
- Latency:
  - clk_out and tick are registered with no combinational path from inputs.
  - New divisor takes effect at most N_old cycles after the load.
- Reset asserted mid-period: all state returns to reset values asynchronously; any pending divisor is discarded.
- Counter never exceeds N-1; no wrap-around beyond 2^WIDTH-1.

Optional Feature:
- Macro: CLKDIV_DUTY50_EN.
- Defined:
  - Odd N produces exactly 50% duty: clk_out is high for N/2 clk_in periods.
  - Implementation: the posedge phase register is OR'd with a falling-edge-of-clk_in retimed copy. The falling-edge register is also async-reset by reset.
  - Even N, tick, running and all handshake behaviour are unchanged.
- Not defined:
  - No negedge logic is present.
  - Odd N gives high for ceil(N/2) cycles, low for floor(N/2) cycles.

Test Plan:
- Release reset, en=1, no loads -> clk_out pattern 1,1,0,0 repeating; tick every 4th cycle coincident with clk_out rise; running=1 from first edge; active_div=4.
- Load div_value=5 in cycle 2 of a period -> div_pending=1 until the boundary; that period still ends after 4 cycles; afterwards clk_out is 3 high / 2 low; active_div=5; div_pending=0.
- Load 7 then 9 on consecutive cycles mid-period -> only 9 is applied at the boundary. Separately, load 0 and load 1 -> active_div=2, clk_out toggles every cycle.
- Deassert en at cycle 1 of an N=6 period -> the full 6-cycle period completes; then clk_out=0, running=0, tick=0 held. Reassert en -> the next edge gives clk_out=1 and tick=1.
- Assert reset at cycle 3 of an N=10 period with a load pending -> outputs go to reset values immediately without waiting for a clock edge; after release active_div=4 and the pending value is gone.
- With CLKDIV_DUTY50_EN, N=5 -> clk_out high for exactly 2.5 clk_in periods per 5-cycle period. Without the macro, N=5 -> 3 high / 2 low.
